// File: rtl/gpu_scanout_if.sv
// rtl/gpu_scanout_if.sv - framebuffer read port between scanout engine and pixel memory
interface gpu_scanout_if #(
    parameter int AW = 32
);
    logic [AW-1:0] o_RdAddr;
    logic          o_RdEn;
    logic [7:0]    i_PixelData;

    modport master (output o_RdAddr, output o_RdEn, input i_PixelData);
    modport slave  (input o_RdAddr, input o_RdEn, output i_PixelData);
endinterface

// File: rtl/gpu_scanout.sv
// rtl/gpu_scanout.sv - VGA scanout engine: timing, scaled fetch addresses, latency-aligned colour
module gpu_scanout #(
    parameter int AW       = 32,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int X_SCALE  = 5,
    parameter int Y_SCALE  = 5,
    parameter int RD_LAT   = 1
) (
    input  logic          i_CLK,
    input  logic          i_RST_N,
    input  logic [AW-1:0] i_BASE_ADDR,
    input  logic          i_MODE,
    gpu_scanout_if.master fb,
    output logic          o_HS,
    output logic          o_VS,
    output logic [3:0]    o_RED,
    output logic [3:0]    o_GREEN,
    output logic [3:0]    o_BLUE,
    output logic          o_FRAME_START
);
    localparam int FB_W  = H_ACTIVE / X_SCALE;
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW   = $clog2(H_TOT + 1);
    localparam int VCW   = $clog2(V_TOT + 1);
    localparam int XW    = $clog2(X_SCALE + 1);
    localparam int YW    = $clog2(Y_SCALE + 1);
    localparam int CW    = $clog2(FB_W + 1);

    localparam logic [HCW-1:0] H_MAX      = HCW'(H_TOT - 1);
    localparam logic [HCW-1:0] H_ACT      = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_ACT_LAST = HCW'(H_ACTIVE - 1);
    localparam logic [HCW-1:0] HS_BEG     = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END     = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_MAX      = VCW'(V_TOT - 1);
    localparam logic [VCW-1:0] V_ACT      = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] VS_BEG     = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END     = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [XW-1:0]  X_LAST     = XW'(X_SCALE - 1);
    localparam logic [YW-1:0]  Y_LAST     = YW'(Y_SCALE - 1);
    localparam logic [AW-1:0]  ROW_STEP   = AW'(FB_W);

    logic [HCW-1:0] r_hc;
    logic [VCW-1:0] r_vc;
    logic [XW-1:0]  r_xsub;
    logic [CW-1:0]  r_col;
    logic [YW-1:0]  r_ysub;
    logic [AW-1:0]  r_row_off;
    logic [AW-1:0]  r_base_sh;
    logic           r_mode_sh;
    logic [AW-1:0]  r_rd_addr;
    logic           r_rd_en;
    logic           r_frame_start;
    logic [RD_LAT:0] r_act_d;
    logic [RD_LAT:0] r_hs_d;
    logic [RD_LAT:0] r_vs_d;
    logic           r_hs;
    logic           r_vs;
    logic [3:0]     r_red;
    logic [3:0]     r_green;
    logic [3:0]     r_blue;

    logic           w_act;
    logic           w_line_end;
    logic           w_frame_top;
    logic           w_hs_raw;
    logic           w_vs_raw;
    logic [AW-1:0]  w_base;
    logic [AW-1:0]  w_row_off;
    logic [AW-1:0]  w_addr;

    assign w_act       = (r_hc < H_ACT) && (r_vc < V_ACT);
    assign w_line_end  = (r_hc == H_MAX);
    assign w_frame_top = (r_hc == '0) && (r_vc == '0);
    assign w_hs_raw    = (r_hc >= HS_BEG) && (r_hc < HS_END);
    assign w_vs_raw    = (r_vc >= VS_BEG) && (r_vc < VS_END);

    // The first fetch of a frame happens on the same edge that latches the new base,
    // so bypass the shadow registers at (0,0) to keep that fetch on the new frame.
    assign w_base    = w_frame_top ? i_BASE_ADDR : r_base_sh;
    assign w_row_off = w_frame_top ? '0 : r_row_off;
    assign w_addr    = w_base + w_row_off + AW'(r_col);

    assign fb.o_RdAddr    = r_rd_addr;
    assign fb.o_RdEn      = r_rd_en;
    assign o_HS           = r_hs;
    assign o_VS           = r_vs;
    assign o_RED          = r_red;
    assign o_GREEN        = r_green;
    assign o_BLUE         = r_blue;
    assign o_FRAME_START  = r_frame_start;

    // Horizontal and vertical raster counters
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_line_end) begin
            r_hc <= '0;
            r_vc <= (r_vc == V_MAX) ? '0 : r_vc + VCW'(1);
        end else begin
            r_hc <= r_hc + HCW'(1);
        end
    end

    // Frame shadow registers and divider-free framebuffer address generation
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_xsub        <= '0;
            r_col         <= '0;
            r_ysub        <= '0;
            r_row_off     <= '0;
            r_base_sh     <= '0;
            r_mode_sh     <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_en       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_top;
            r_rd_en       <= w_act;
            if (w_act) begin
                r_rd_addr <= w_addr;
            end
            if (w_frame_top) begin
                r_base_sh <= i_BASE_ADDR;
                r_mode_sh <= i_MODE;
            end
            if (w_line_end) begin
                r_xsub <= '0;
                r_col  <= '0;
            end else if (w_act) begin
                if (r_xsub == X_LAST) begin
                    r_xsub <= '0;
                    r_col  <= r_col + CW'(1);
                end else begin
                    r_xsub <= r_xsub + XW'(1);
                end
            end
            if (w_frame_top) begin
                r_ysub    <= '0;
                r_row_off <= '0;
            end else if (w_act && (r_hc == H_ACT_LAST)) begin
                if (r_ysub == Y_LAST) begin
                    r_ysub    <= '0;
                    r_row_off <= r_row_off + ROW_STEP;
                end else begin
                    r_ysub <= r_ysub + YW'(1);
                end
            end
        end
    end

    // Delay active/sync flags to line up with pixel data returning from memory
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_act_d <= '0;
            r_hs_d  <= '0;
            r_vs_d  <= '0;
        end else begin
            r_act_d <= {r_act_d[RD_LAT-1:0], w_act};
            r_hs_d  <= {r_hs_d[RD_LAT-1:0], w_hs_raw};
            r_vs_d  <= {r_vs_d[RD_LAT-1:0], w_vs_raw};
        end
    end

    // Final pin register: colour decode plus syncs, all sharing the same latency
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_hs <= r_hs_d[RD_LAT] ? HS_POL : ~HS_POL;
            r_vs <= r_vs_d[RD_LAT] ? VS_POL : ~VS_POL;
            if (!r_act_d[RD_LAT]) begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end else if (r_mode_sh) begin
                r_red   <= fb.i_PixelData[7:4];
                r_green <= fb.i_PixelData[7:4];
                r_blue  <= fb.i_PixelData[7:4];
            end else begin
                r_red   <= {fb.i_PixelData[2:0], 1'b1};
                r_green <= {fb.i_PixelData[5:3], 1'b1};
                r_blue  <= {fb.i_PixelData[7:6], 2'b10};
            end
        end
    end
endmodule

// File: tb/tb_gpu_scanout.sv
// tb/tb_gpu_scanout.sv - scoreboard bench for gpu_scanout (default and small-timing instances)
module tb_gpu_scanout;
    localparam bit SM_HS_POL = 1'b0;
    localparam bit SM_VS_POL = 1'b1;

    logic        clk;
    logic        rst_n;
    logic [31:0] base_big;
    logic [31:0] base_sm;
    logic        mode_sm;
    logic        hs_big, vs_big, fs_big;
    logic [3:0]  r_big, g_big, b_big;
    logic        hs_sm, vs_sm, fs_sm;
    logic [3:0]  r_sm, g_sm, b_sm;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] q_big[$];
    logic [14:0] q_sm[$];
    logic [31:0] sm_pipe[0:2];
    logic [31:0] big_exp;
    logic [14:0] sm_exp;
    bit          sm_on;
    int          sm_dly;
    bit          ok;

    gpu_scanout_if #(.AW(32)) fb_big();
    gpu_scanout_if #(.AW(32)) fb_sm();

    gpu_scanout u_big (
        .i_CLK(clk), .i_RST_N(rst_n), .i_BASE_ADDR(base_big), .i_MODE(1'b0),
        .fb(fb_big), .o_HS(hs_big), .o_VS(vs_big),
        .o_RED(r_big), .o_GREEN(g_big), .o_BLUE(b_big), .o_FRAME_START(fs_big)
    );

    gpu_scanout #(
        .AW(32), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(SM_HS_POL), .VS_POL(SM_VS_POL), .X_SCALE(2), .Y_SCALE(2), .RD_LAT(3)
    ) u_sm (
        .i_CLK(clk), .i_RST_N(rst_n), .i_BASE_ADDR(base_sm), .i_MODE(mode_sm),
        .fb(fb_sm), .o_HS(hs_sm), .o_VS(vs_sm),
        .o_RED(r_sm), .o_GREEN(g_sm), .o_BLUE(b_sm), .o_FRAME_START(fs_sm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: big instance reads zeros, small instance returns addr[7:0] after 3 cycles
    assign fb_big.i_PixelData = 8'h00;
    assign fb_sm.i_PixelData  = sm_pipe[2][7:0];
    always @(posedge clk) begin
        sm_pipe[0] <= fb_sm.o_RdAddr;
        sm_pipe[1] <= sm_pipe[0];
        sm_pipe[2] <= sm_pipe[1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {hs,vs,r,g,b} at the pins for raster position (h,v) of the small timing
    function automatic logic [14:0] exp_pin(input int h, input int v,
                                            input logic [31:0] base, input logic mode);
        logic [7:0] d;
        logic [3:0] r, g, b;
        logic hs, vs;
        hs = (h >= 9 && h < 11) ? SM_HS_POL : ~SM_HS_POL;
        vs = (v == 5) ? SM_VS_POL : ~SM_VS_POL;
        r = 4'h0; g = 4'h0; b = 4'h0;
        if (h < 8 && v < 4) begin
            d = 8'(base + 32'((v / 2) * 4 + h / 2));
            if (mode) begin
                r = d[7:4]; g = d[7:4]; b = d[7:4];
            end else begin
                r = {d[2:0], 1'b1}; g = {d[5:3], 1'b1}; b = {d[7:6], 2'b10};
            end
        end
        return {hs, vs, r, g, b};
    endfunction

    task automatic push_sm_frame(input logic [31:0] base, input logic mode);
        for (int v = 0; v < 7; v++)
            for (int h = 0; h < 12; h++)
                q_sm.push_back(exp_pin(h, v, base, mode));
    endtask

    task automatic wait_fs_sm(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fs_sm) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_state();
        check("rst_big_addr", fb_big.o_RdAddr, 32'h0);
        check("rst_big_en", 32'(fb_big.o_RdEn), 32'h0);
        check("rst_big_rgb", 32'({r_big, g_big, b_big}), 32'h0);
        check("rst_big_hs", 32'(hs_big), 32'h0);
        check("rst_big_vs", 32'(vs_big), 32'h0);
        check("rst_big_fs", 32'(fs_big), 32'h0);
        check("rst_sm_addr", fb_sm.o_RdAddr, 32'h0);
        check("rst_sm_en", 32'(fb_sm.o_RdEn), 32'h0);
        check("rst_sm_rgb", 32'({r_sm, g_sm, b_sm}), 32'h0);
        check("rst_sm_hs", 32'(hs_sm), 32'h1);
        check("rst_sm_vs", 32'(vs_sm), 32'h0);
        check("rst_sm_fs", 32'(fs_sm), 32'h0);
    endtask

    // Address monitor for the default-timing instance: one expected entry per real fetch
    always @(negedge clk) begin
        if (rst_n && fb_big.o_RdEn && q_big.size() > 0) begin
            big_exp = q_big.pop_front();
            check("big_addr", fb_big.o_RdAddr, big_exp);
        end
    end

    // Pin monitor for the small instance: starts 4 cycles after the frame-start pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            sm_on  = 1'b0;
            sm_dly = 0;
        end else if (!sm_on) begin
            if (fs_sm) begin
                sm_on  = 1'b1;
                sm_dly = 3;
            end
        end else if (sm_dly > 0) begin
            sm_dly--;
        end else if (q_sm.size() > 0) begin
            sm_exp = q_sm.pop_front();
            check("sm_pins", 32'({hs_sm, vs_sm, r_sm, g_sm, b_sm}), 32'(sm_exp));
        end
    end

    initial begin
        rst_n    = 1'b0;
        base_big = 32'h1000;
        base_sm  = 32'hF8;
        mode_sm  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();

        for (int line = 0; line < 6; line++)
            for (int i = 0; i < 800; i++)
                q_big.push_back(32'h1000 + 32'((line / 5) * 160 + i / 5));
        push_sm_frame(32'hF8, 1'b0);
        rst_n = 1'b1;

        wait_fs_sm(ok);
        check("sm_fs_frame0", 32'(ok), 32'h1);
        repeat (40) @(negedge clk);
        base_sm = 32'hA2;
        mode_sm = 1'b1;
        push_sm_frame(32'hA2, 1'b1);

        wait_fs_sm(ok);
        check("sm_fs_frame1", 32'(ok), 32'h1);
        repeat (40) @(negedge clk);
        base_sm = 32'h10;
        mode_sm = 1'b0;
        push_sm_frame(32'h10, 1'b0);

        wait_fs_sm(ok);
        check("sm_fs_frame2", 32'(ok), 32'h1);
        for (int i = 0; i < 200 && q_sm.size() > 0; i++) @(negedge clk);
        check("sm_queue_drained", 32'(q_sm.size()), 32'h0);
        for (int i = 0; i < 8000 && q_big.size() > 0; i++) @(negedge clk);
        check("big_queue_drained", 32'(q_big.size()), 32'h0);

        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("big_fs_after_reset", 32'(fs_big), 32'h1);
        check("sm_fs_after_reset", 32'(fs_sm), 32'h1);
        check("big_first_addr", fb_big.o_RdAddr, 32'h1000);
        check("sm_first_addr", fb_sm.o_RdAddr, 32'h10);
        check("sm_first_en", 32'(fb_sm.o_RdEn), 32'h1);
        @(negedge clk);
        check("big_fs_one_cycle", 32'(fs_big), 32'h0);
        check("sm_fs_one_cycle", 32'(fs_sm), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
